// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder: FSM state encoding
// and the default operand/counter widths.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between a controller (master) and the serial
// adder (slave): operands in, status and registered result out.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell built from two half-adder cells and an OR;
// the half-adder cell is kept alongside it as its only user.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  ha_cell u_ha0 (
    .a (a),
    .b (b),
    .s (w_s1),
    .c (w_c1)
  );

  ha_cell u_ha1 (
    .a (w_s1),
    .b (cin),
    .s (s),
    .c (w_c2)
  );

  // Both half-adder carries can never be high together, so OR suffices.
  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per
// clock, registered carry, start/done handshake with back-to-back restart.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic           clk,
  input logic           reset,
  serial_adder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic w_s;
  logic w_c;
  logic w_last;

  fa_cell u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc   <= {w_s, r_acc[WIDTH-1:1]};
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // Publish only the complete word so sum never shows partial shifts.
          if (w_last) begin
            r_sum   <= {w_s, r_acc[WIDTH-1:1]};
            r_cout  <= w_c;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
